// File: rtl/sdram_read_pkg.sv
// Shared SDRAM command/timing constants and the read-engine state encoding.
// The guarded macro block is the controller-wide sdram_include set.
`ifndef SDRAM_INCLUDE_SV
`define SDRAM_INCLUDE_SV
`define SDRAM_CMD_LOAD_MODE 3'b000
`define SDRAM_CMD_REFRESH   3'b001
`define SDRAM_CMD_PRECHARGE 3'b010
`define SDRAM_CMD_ACTIVATE  3'b011
`define SDRAM_CMD_WRITE     3'b100
`define SDRAM_CMD_READ      3'b101
`define SDRAM_CMD_TERM      3'b110
`define SDRAM_CMD_NOP       3'b111
`define T_RCD       2
`define T_RP        2
`define T_WR        2
`define CAS_LATENCY 2
`endif

package sdram_read_pkg;

    localparam int DATA_W = 16;

    localparam logic [2:0] CMD_NOP  = `SDRAM_CMD_NOP;
    localparam logic [2:0] CMD_ACT  = `SDRAM_CMD_ACTIVATE;
    localparam logic [2:0] CMD_READ = `SDRAM_CMD_READ;
    localparam logic [2:0] CMD_TERM = `SDRAM_CMD_TERM;
    localparam logic [2:0] CMD_PRE  = `SDRAM_CMD_PRECHARGE;

    localparam int CAS_LATENCY_DEF = `CAS_LATENCY;
    localparam int T_RCD_DEF       = `T_RCD;
    localparam int T_RP_DEF        = `T_RP;

    typedef logic [3:0] delay_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACTIVATE,
        ST_READ_CMD,
        ST_READ_TOP,
        ST_READ_BOTTOM,
        ST_BURST_TERM,
        ST_PRECHARGE
    } state_t;

endpackage

// File: rtl/sdram_read_capture.sv
// CAS-latency tag pipeline and 16->32 bit half-packer for returned read data.
// A tag enters with each read slot and emerges exactly when its half is on data_in.
module sdram_read_capture
    import sdram_read_pkg::*;
#(
    parameter int CAS_LATENCY = CAS_LATENCY_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  slot_valid,
    input  logic                  slot_second,
    input  logic [DATA_W-1:0]     data_in,
    output logic [2*DATA_W-1:0]   fifo_data,
    output logic                  fifo_write,
    output logic                  busy
);

    logic [CAS_LATENCY-1:0] vld_p;
    logic [CAS_LATENCY-1:0] second_p;
    logic [DATA_W-1:0]      upper_p;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p      <= '0;
            second_p   <= '0;
            upper_p    <= '0;
            fifo_data  <= '0;
            fifo_write <= 1'b0;
        end else begin
            vld_p      <= {vld_p[CAS_LATENCY-2:0], slot_valid};
            second_p   <= {second_p[CAS_LATENCY-2:0], slot_valid & slot_second};
            fifo_write <= 1'b0;
            // tag emerges: first half is held, second half completes the word
            if (vld_p[CAS_LATENCY-1]) begin
                if (second_p[CAS_LATENCY-1]) begin
                    fifo_data  <= {upper_p, data_in};
                    fifo_write <= 1'b1;
                end else begin
                    upper_p <= data_in;
                end
            end
        end
    end

    assign busy = slot_valid | (|vld_p);

endmodule

// File: rtl/sdram_read.sv
// Read-side SDRAM engine: ACTIVATE, full-page READ burst, TERM, PRECHARGE,
// split at row ends, refresh requests and FIFO back-pressure.
module sdram_read
    import sdram_read_pkg::*;
#(
    parameter int CAS_LATENCY = CAS_LATENCY_DEF,
    parameter int T_RCD       = T_RCD_DEF,
    parameter int T_RP        = T_RP_DEF
) (
    input  logic                clk,
    input  logic                rst,
    output logic [2:0]          command,
    output logic [11:0]         address,
    output logic [1:0]          bank,
    input  logic [DATA_W-1:0]   data_in,
    output logic [1:0]          data_mask,
    output logic                idle,
    input  logic                enable,
    input  logic [21:0]         app_address,
    input  logic                auto_refresh,
    output logic                wait_for_refresh,
    output logic [2*DATA_W-1:0] fifo_data,
    output logic                fifo_write,
    input  logic                fifo_ready,
    input  logic                fifo_almost_full,
    output logic                fifo_activate,
    input  logic [23:0]         fifo_size
);

    state_t      state, state_n;
    delay_t      delay, delay_n;
    logic [2:0]  command_n;
    logic [11:0] address_n;
    logic [1:0]  bank_n;
    logic [21:0] read_address, read_address_n;
    logic [23:0] words_remaining, words_remaining_n;
    logic        fifo_activate_n;
    logic        wait_for_refresh_n;
    logic        slot_valid, slot_valid_n;
    logic        slot_second, slot_second_n;
    logic        capture_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= ST_IDLE;
            delay            <= '0;
            command          <= CMD_NOP;
            address          <= '0;
            bank             <= '0;
            read_address     <= '0;
            words_remaining  <= '0;
            fifo_activate    <= 1'b0;
            wait_for_refresh <= 1'b0;
            slot_valid       <= 1'b0;
            slot_second      <= 1'b0;
        end else begin
            state            <= state_n;
            delay            <= delay_n;
            command          <= command_n;
            address          <= address_n;
            bank             <= bank_n;
            read_address     <= read_address_n;
            words_remaining  <= words_remaining_n;
            fifo_activate    <= fifo_activate_n;
            wait_for_refresh <= wait_for_refresh_n;
            slot_valid       <= slot_valid_n;
            slot_second      <= slot_second_n;
        end
    end

    always_comb begin
        state_n            = state;
        delay_n            = delay;
        command_n          = CMD_NOP;
        address_n          = address;
        bank_n             = bank;
        read_address_n     = read_address;
        words_remaining_n  = words_remaining;
        fifo_activate_n    = fifo_activate;
        wait_for_refresh_n = wait_for_refresh;
        slot_valid_n       = 1'b0;
        slot_second_n      = 1'b0;

        if (delay != '0) begin
            delay_n = delay - delay_t'(1);
        end else begin
            wait_for_refresh_n = 1'b0;
            case (state)
                ST_IDLE: begin
                    wait_for_refresh_n = 1'b1;
                    if (enable && fifo_ready) begin
                        read_address_n    = app_address;
                        words_remaining_n = fifo_size;
                        fifo_activate_n   = 1'b1;
                        state_n           = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (auto_refresh) begin
                        wait_for_refresh_n = 1'b1;
                    end else if (words_remaining == '0) begin
                        fifo_activate_n = 1'b0;
                        state_n         = ST_IDLE;
                    end else if (!fifo_almost_full) begin
                        state_n = ST_ACTIVATE;
                    end
                end
                ST_ACTIVATE: begin
                    if (auto_refresh) begin
                        state_n = ST_WAIT;
                    end else begin
                        command_n = CMD_ACT;
                        bank_n    = read_address[21:20];
                        address_n = read_address[19:8];
                        delay_n   = delay_t'(T_RCD);
                        state_n   = ST_READ_CMD;
                    end
                end
                ST_READ_CMD: begin
                    command_n    = CMD_READ;
                    address_n    = {4'b0000, read_address[7:0]};
                    slot_valid_n = 1'b1;
                    state_n      = ST_READ_BOTTOM;
                end
                ST_READ_TOP: begin
                    slot_valid_n = 1'b1;
                    state_n      = ST_READ_BOTTOM;
                end
                ST_READ_BOTTOM: begin
                    slot_valid_n      = 1'b1;
                    slot_second_n     = 1'b1;
                    read_address_n    = read_address + 22'd2;
                    words_remaining_n = words_remaining - 24'd1;
                    // only stop on a word boundary: this is the second-half slot
                    if (words_remaining_n == '0 || read_address_n[7:0] == 8'h00 ||
                        auto_refresh || fifo_almost_full)
                        state_n = ST_BURST_TERM;
                    else
                        state_n = ST_READ_TOP;
                end
                ST_BURST_TERM: begin
                    command_n = CMD_TERM;
                    delay_n   = delay_t'(CAS_LATENCY);
                    state_n   = ST_PRECHARGE;
                end
                ST_PRECHARGE: begin
                    command_n = CMD_PRE;
                    delay_n   = delay_t'(T_RP);
                    state_n   = ST_WAIT;
                end
                default: begin
                    state_n = ST_IDLE;
                end
            endcase
        end
    end

    sdram_read_capture #(
        .CAS_LATENCY (CAS_LATENCY)
    ) u_capture (
        .clk         (clk),
        .rst         (rst),
        .slot_valid  (slot_valid),
        .slot_second (slot_second),
        .data_in     (data_in),
        .fifo_data   (fifo_data),
        .fifo_write  (fifo_write),
        .busy        (capture_busy)
    );

    assign data_mask = 2'b00;
    assign idle      = (delay == '0) && (state == ST_IDLE || state == ST_WAIT) && !capture_busy;

endmodule

// File: tb/tb_sdram_read.sv
// Self-checking bench for sdram_read: SDRAM data model, word scoreboard,
// directed vector table, multi-cycle corner sequences and randomized reads.
module tb_sdram_read;

    localparam int CL    = 2;
    localparam int TRCD  = 2;
    localparam int TRP   = 2;
    localparam int LIMIT = 4000;

    localparam logic [2:0] C_NOP  = 3'b111;
    localparam logic [2:0] C_ACT  = 3'b011;
    localparam logic [2:0] C_READ = 3'b101;
    localparam logic [2:0] C_TERM = 3'b110;
    localparam logic [2:0] C_PRE  = 3'b010;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  command;
    logic [11:0] address;
    logic [1:0]  bank;
    logic [15:0] data_in = 16'h0000;
    logic [1:0]  data_mask;
    logic        idle;
    logic        enable = 1'b0;
    logic [21:0] app_address = '0;
    logic        auto_refresh = 1'b0;
    logic        wait_for_refresh;
    logic [31:0] fifo_data;
    logic        fifo_write;
    logic        fifo_ready = 1'b1;
    logic        fifo_almost_full = 1'b0;
    logic        fifo_activate;
    logic [23:0] fifo_size = '0;

    sdram_read #(.CAS_LATENCY(CL), .T_RCD(TRCD), .T_RP(TRP)) dut (
        .clk(clk), .rst(rst), .command(command), .address(address), .bank(bank),
        .data_in(data_in), .data_mask(data_mask), .idle(idle), .enable(enable),
        .app_address(app_address), .auto_refresh(auto_refresh),
        .wait_for_refresh(wait_for_refresh), .fifo_data(fifo_data),
        .fifo_write(fifo_write), .fifo_ready(fifo_ready),
        .fifo_almost_full(fifo_almost_full), .fifo_activate(fifo_activate),
        .fifo_size(fifo_size)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    // each 16-bit half carries its own address: {bank, row[5:0], column}
    function automatic logic [15:0] half_of(input logic [21:0] a);
        return {a[21:20], a[13:8], a[7:0]};
    endfunction

    logic [31:0] exp_q[$];
    logic [13:0] act_q[$];
    logic [7:0]  read_q[$];
    int          cyc = 0;
    int          wr_cnt = 0;
    int          cmd_cnt = 0;
    int          last_wr_cyc = -100;
    logic [31:0] first_word = '0;
    bit          fa_seen = 0, bad_cmd = 0, dqm_bad = 0;
    bit          burst_on = 0;
    logic [1:0]  open_bank = '0;
    logic [11:0] open_row = '0;
    logic [7:0]  bcol = '0;
    logic [15:0] dq_line [CL];

    initial for (int i = 0; i < CL; i++) dq_line[i] = 16'hDEAD;

    // SDRAM behaviour and output scoreboard, sampled mid-cycle
    always @(negedge clk) begin
        cyc++;
        if (fifo_activate) fa_seen = 1;
        if (data_mask != 2'b00) dqm_bad = 1;
        if (rst) burst_on = 0;
        else begin
            case (command)
                C_ACT:  begin act_q.push_back({bank, address}); open_bank = bank; open_row = address; cmd_cnt++; end
                C_READ: begin read_q.push_back(address[7:0]); burst_on = 1; bcol = address[7:0]; cmd_cnt++; end
                C_TERM, C_PRE: begin burst_on = 0; cmd_cnt++; end
                C_NOP: ;
                default: bad_cmd = 1;
            endcase
        end
        data_in = dq_line[CL-1];
        for (int i = CL-1; i > 0; i--) dq_line[i] = dq_line[i-1];
        dq_line[0] = burst_on ? {open_bank, open_row[5:0], bcol} : 16'hDEAD;
        if (burst_on) bcol = bcol + 8'd1;
        if (fifo_write) begin
            if (wr_cnt == 0) first_word = fifo_data;
            wr_cnt++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                $display("FAIL extra_write: got %0h expected no write", fifo_data);
            end else begin
                check("word", fifo_data, exp_q.pop_front());
            end
        end
    end

    task automatic start_read(input logic [21:0] a, input logic [23:0] n);
        exp_q.delete(); act_q.delete(); read_q.delete();
        wr_cnt = 0; cmd_cnt = 0; fa_seen = 0;
        for (int i = 0; i < int'(n); i++) begin
            logic [21:0] ad;
            ad = a + 22'(2 * i);
            exp_q.push_back({half_of(ad), half_of(ad + 22'd1)});
        end
        @(posedge clk); #1;
        app_address = a; fifo_size = n; enable = 1'b1;
        @(posedge clk); #1;
        enable = 1'b0;
    endtask

    task automatic finish_read(input int n, input bit rnd);
        int k = 0;
        while (!(fifo_activate == 1'b0 && idle) && k < LIMIT) begin
            if (rnd) begin
                auto_refresh     = ($urandom_range(0, 15) == 0);
                fifo_almost_full = ($urandom_range(0, 9) == 0);
            end
            @(posedge clk); #1;
            k++;
        end
        auto_refresh = 1'b0; fifo_almost_full = 1'b0;
        check("done_in_budget", k < LIMIT, 1);
        check("word_count", wr_cnt, n);
        check("none_missing", exp_q.size(), 0);
    endtask

    task automatic wait_words(input int n);
        int k = 0;
        while (wr_cnt < n && k < LIMIT) begin @(posedge clk); #1; k++; end
        check("reach_words", k < LIMIT, 1);
    endtask

    typedef struct {
        logic [21:0] addr;
        logic [23:0] size;
        logic [31:0] word0;
        logic [13:0] act0;
        logic [7:0]  col0;
        logic [13:0] act_last;
        logic [7:0]  col_last;
        int          reads;
    } vec_t;

    vec_t vecs[4];

    initial begin
        vecs[0] = '{22'h000010, 24'd4, 32'h00100011, {2'd0, 12'h000}, 8'h10, {2'd0, 12'h000}, 8'h10, 1};
        vecs[1] = '{22'h0000FC, 24'd3, 32'h00FC00FD, {2'd0, 12'h000}, 8'hFC, {2'd0, 12'h001}, 8'h00, 2};
        vecs[2] = '{22'h100200, 24'd2, 32'h42004201, {2'd1, 12'h002}, 8'h00, {2'd1, 12'h002}, 8'h00, 1};
        vecs[3] = '{22'h3FFFFC, 24'd2, 32'hFFFCFFFD, {2'd3, 12'hFFF}, 8'hFC, {2'd3, 12'hFFF}, 8'hFC, 1};

        repeat (3) @(posedge clk);
        #1;
        check("rst_command", command, C_NOP);
        check("rst_address", address, 0);
        check("rst_bank", bank, 0);
        check("rst_dqm", data_mask, 0);
        check("rst_fifo_data", fifo_data, 0);
        check("rst_fifo_write", fifo_write, 0);
        check("rst_fifo_activate", fifo_activate, 0);
        check("rst_wait_for_refresh", wait_for_refresh, 0);
        check("rst_idle", idle, 1);
        rst = 1'b0;

        for (int v = 0; v < 4; v++) begin
            start_read(vecs[v].addr, vecs[v].size);
            finish_read(int'(vecs[v].size), 0);
            check("first_word", first_word, vecs[v].word0);
            check("read_cmds", read_q.size(), vecs[v].reads);
            check("act_cmds", act_q.size(), vecs[v].reads);
            check("all_cmds", cmd_cnt, 4 * vecs[v].reads);
            if (act_q.size() > 0) begin
                check("act0", act_q[0], vecs[v].act0);
                check("act_last", act_q[$], vecs[v].act_last);
            end
            if (read_q.size() > 0) begin
                check("col0", read_q[0], vecs[v].col0);
                check("col_last", read_q[$], vecs[v].col_last);
            end
        end

        // zero-length transfer
        start_read(22'h001234, 24'd0);
        finish_read(0, 0);
        check("zero_cmds", cmd_cnt, 0);
        check("zero_fa_pulse", fa_seen, 1);
        check("zero_fa_clear", fifo_activate, 0);

        // refresh request in the middle of a long burst
        begin
            int k = 0;
            int snap;
            bit nop_ok = 1;
            start_read(22'h000000, 24'd64);
            wait_words(5);
            auto_refresh = 1'b1;
            while (!wait_for_refresh && k < LIMIT) begin @(posedge clk); #1; k++; end
            check("refresh_parked", wait_for_refresh, 1);
            snap = wr_cnt;
            repeat (8) begin
                @(posedge clk); #1;
                if (command != C_NOP) nop_ok = 0;
            end
            check("refresh_nop_only", nop_ok, 1);
            check("refresh_no_writes", wr_cnt, snap);
            check("refresh_partial", snap < 64, 1);
            auto_refresh = 1'b0;
            finish_read(64, 0);
            check("refresh_reactivated", act_q.size() >= 2, 1);
        end

        // FIFO back-pressure for 10 cycles during a 32-word read
        begin
            int a0;
            int acts;
            start_read(22'h000040, 24'd32);
            wait_words(3);
            fifo_almost_full = 1'b1;
            a0 = cyc;
            acts = act_q.size();
            repeat (10) begin @(posedge clk); #1; end
            check("af_drain_only", last_wr_cyc < a0 + CL + 5, 1);
            check("af_no_act", act_q.size(), acts);
            fifo_almost_full = 1'b0;
            finish_read(32, 0);
            check("af_resumed", act_q.size(), 2);
        end

        // reset while the burst is in READ_TOP
        begin
            int k = 0;
            int snap;
            start_read(22'h000020, 24'd16);
            while (command != C_READ && k < LIMIT) begin @(posedge clk); #1; k++; end
            check("saw_read", command, C_READ);
            @(posedge clk); #1;
            rst = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            check("mid_rst_command", command, C_NOP);
            check("mid_rst_address", address, 0);
            check("mid_rst_bank", bank, 0);
            check("mid_rst_fifo_data", fifo_data, 0);
            check("mid_rst_fifo_write", fifo_write, 0);
            check("mid_rst_fifo_activate", fifo_activate, 0);
            check("mid_rst_wfr", wait_for_refresh, 0);
            snap = wr_cnt;
            repeat (10) begin @(posedge clk); #1; end
            check("mid_rst_no_writes", wr_cnt, snap);
            check("mid_rst_idle", idle, 1);
            exp_q.delete();
        end

        // randomized reads with random refresh and back-pressure
        for (int t = 0; t < 6; t++) begin
            logic [21:0] a;
            logic [23:0] n;
            a = 22'($urandom) & 22'h3FFFFE;
            n = 24'($urandom_range(1, 40));
            start_read(a, n);
            finish_read(int'(n), 1);
        end

        check("dqm_always_zero", dqm_bad, 0);
        check("legal_commands", bad_cmd, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sdram_read.md
Name: sdram_read

Overview:
- Read-side engine of the wb_sdram controller; the counterpart to the write engine.
- When the arbiter enables it, it reads a block of 32-bit words from a 16-bit SDR SDRAM, starting at a latched address.
- It issues ACTIVATE, then full-page READ bursts, then BURST TERMINATE and PRECHARGE, splitting the transfer at row ends and auto-refresh requests.
- Returned halves are packed into 32-bit words and pushed into the read FIFO toward the Wishbone side.

Parameters:
- CAS_LATENCY, 2, cycles from a read slot to its data on data_in (2 or 3).
- T_RCD, `T_RCD, ACTIVATE-to-READ NOP cycles.
- T_RP, `T_RP, PRECHARGE NOP cycles.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- command  out  3  SDRAM command; `SDRAM_CMD_* encoding.
- address  out  12  SDRAM A[11:0].
- bank  out  2  SDRAM BA.
- data_in  in  16  SDRAM DQ read data.
- data_mask  out  2  DQM; driven 2'b00 whenever reading.
- idle  out  1  engine quiescent; arbiter may hand the bus elsewhere.
- enable  in  1  arbiter grant / read request.
- app_address  in  22  start address: [21:20] bank, [19:8] row, [7:0] column in 16-bit units.
- auto_refresh  in  1  refresh pending; engine must close its row.
- wait_for_refresh  out  1  engine is parked and refresh may proceed.
- fifo_data  out  32  packed word {first half, second half}.
- fifo_write  out  1  one-cycle push strobe.
- fifo_ready  in  1  FIFO available for a new transfer.
- fifo_almost_full  in  1  fewer than CAS_LATENCY+2 words free.
- fifo_activate  out  1  held high for the duration of a transfer.
- fifo_size  in  24  number of 32-bit words to read.

Behaviour:
- Reset values:
  - command = NOP; address = 0; bank = 0; data_mask = 0.
  - fifo_data = 0; fifo_write = 0; fifo_activate = 0; wait_for_refresh = 0.
  - State = IDLE; delay = 0; read_address = 0; words_remaining = 0.
  - Capture pipeline and half-packer cleared.
  - Reset mid-burst aborts immediately with no further fifo_write; the open row is left to the controller's re-init.
- Delay counter: while delay > 0, command = NOP and delay decrements; the state machine is frozen.
- Pipeline: the capture pipeline keeps running during delay.
- States:
  - IDLE: assert wait_for_refresh. On enable && fifo_ready: latch read_address = app_address, words_remaining = fifo_size, fifo_activate = 1, go to WAIT.
  - WAIT:
    - If auto_refresh: assert wait_for_refresh and stay.
    - Else if words_remaining == 0: fifo_activate = 0, go to IDLE.
    - Else if fifo_almost_full: stay.
    - Else go to ACTIVATE.
  - ACTIVATE:
    - If auto_refresh: go to WAIT.
    - Else: command = ACT, bank = read_address[21:20], address = row, delay = T_RCD, go to READ_CMD.
  - READ_CMD: command = READ, address = {4'b0, column}, first half slot, go to READ_BOTTOM.
  - READ_TOP: command = NOP, first half slot, go to READ_BOTTOM.
  - READ_BOTTOM: command = NOP, second half slot.
    - read_address += 2; words_remaining -= 1.
    - If the new words_remaining == 0, or the new read_address[7:0] == 0, or auto_refresh, or fifo_almost_full: go to BURST_TERM.
    - Else go to READ_TOP.
  - BURST_TERM: command = TERM, delay = CAS_LATENCY (drain in-flight data), go to PRECHARGE.
  - PRECHARGE: command = PRE, delay = T_RP, go to WAIT.
  - Any other state: go to IDLE.
- Slot rule: every first/second half slot inserts a tagged valid bit into a CAS_LATENCY-deep shift register.
  - When a first-tagged bit emerges, data_in is latched as the upper half.
  - When a second-tagged bit emerges: fifo_data = {upper, data_in} and fifo_write = 1 for one cycle.
- A burst is never split inside a 32-bit word; termination happens only after a second half slot.
- idle = (delay == 0) && (state is IDLE or WAIT) && capture pipeline empty.
- fifo_size == 0: IDLE → WAIT → IDLE; no SDRAM commands issued, zero fifo_write.
- Address wrap: column wrap re-activates the next row; row/bank carry is natural 22-bit addition.

Decomposition:
- sdram_include carries the shared constants: `SDRAM_CMD_*, `T_RCD, `T_RP, `T_WR. Add `CAS_LATENCY there.
- One sub-module, sdram_read_capture:
  - Holds the CAS-latency tag shift register and the half-packer.
  - Inputs: clk, rst, slot_valid, slot_second, data_in.
  - Outputs: fifo_data, fifo_write, busy.

Test Plan:
- Read of 4 words at 0x000010; SDRAM model returns half = column:
  - Expect ACT at row 0x000 then one READ at column 0x10.
  - Expect 4 fifo_write with fifo_data 0x00100011, 0x00120013, 0x00140015, 0x00160017.
  - Then TERM, PRE, and idle high.
- Read of 3 words at 0x0000FC:
  - Expect two words from row 0.
  - Then TERM/PRE, then ACT at row 1, column 0.
  - Total of 3 words, in order.
- auto_refresh asserted mid-burst of 64 words:
  - Burst ends only after a complete word; wait_for_refresh asserted in WAIT.
  - After auto_refresh drops, the read resumes at the next address with no lost or duplicated words.
- fifo_almost_full asserted for 10 cycles during a 32-word read:
  - Engine parks in WAIT; no fifo_write beyond the CAS_LATENCY drain.
  - On release, resumes; 32 words total.
- fifo_size = 0 with enable: no commands other than NOP; fifo_activate pulses and clears; zero writes.
- rst asserted during READ_TOP: the next cycle shows all outputs at reset values, with fifo_write = 0 thereafter.
